// File: rtl/exc_arbiter.sv
// MEM-stage exception collector: synchronises interrupts, forwards in-flight mtc0
// writes, prioritises exception flags and emits a one-cycle commit/flush to CP0.
module exc_arbiter #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic        stall_i,
   input  logic [31:0] pc_i,
   input  logic        is_in_delayslot_i,
   input  logic [31:0] mem_addr_i,
   input  logic [8:0]  exc_flags_i,
   input  logic [5:0]  ext_int_i,
   input  logic        timer_int_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        cp0_we_i,
   input  logic [4:0]  cp0_waddr_i,
   input  logic [31:0] cp0_wdata_i,
   output logic [5:0]  int_o,
   output logic [31:0] excepttype_o,
   output logic [31:0] current_inst_addr_o,
   output logic        is_in_delayslot_o,
   output logic [31:0] bad_addr_o,
   output logic        flush_o,
   output logic [31:0] newpc_o
);

   localparam logic [4:0] ADDR_STATUS = 5'd12;
   localparam logic [4:0] ADDR_CAUSE  = 5'd13;
   localparam logic [4:0] ADDR_EPC    = 5'd14;

   logic [SYNC_STAGES-1:0][5:0] sync_q;
   logic [5:0]  int_vec;
   logic [31:0] status_f;
   logic [31:0] epc_f;
   logic [1:0]  cause_sw_f;
   logic [7:0]  cause_ip_f;
   logic        ie_ok;
   logic        int_req;
   logic        int_sel;
   logic        int_pend_q;
   logic        block_q;
   logic        commit;
   logic [4:0]  code;
   logic [31:0] bad_sel;
   logic        unused_bits;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ext_int_i};
      end
   end

   assign int_vec = {sync_q[SYNC_STAGES-1][5] | timer_int_i, sync_q[SYNC_STAGES-1][4:0]};

   assign status_f   = (cp0_we_i && cp0_waddr_i == ADDR_STATUS) ? cp0_wdata_i : cp0_status_i;
   assign epc_f      = (cp0_we_i && cp0_waddr_i == ADDR_EPC)    ? cp0_wdata_i : cp0_epc_i;
   assign cause_sw_f = (cp0_we_i && cp0_waddr_i == ADDR_CAUSE)  ? cp0_wdata_i[9:8] : cp0_cause_i[9:8];
   assign cause_ip_f = {int_vec, cause_sw_f};

   assign ie_ok   = status_f[0] & ~status_f[1];
   assign int_req = ie_ok & (|(cause_ip_f & status_f[15:8]));
   // The pending latch remembers a source that dropped, but the enable is always
   // taken from the current (forwarded) status so an mtc0 clearing IE wins.
   assign int_sel = (int_pend_q | int_req) & ie_ok;

   assign commit = ~rst & valid_i & ~stall_i & ~block_q & (int_sel | (|exc_flags_i));

   always_ff @(posedge clk) begin
      if (rst) begin
         int_pend_q <= 1'b0;
         block_q    <= 1'b0;
      end else begin
         int_pend_q <= (commit && int_sel) ? 1'b0 : int_req;
         block_q    <= commit;
      end
   end

   always_comb begin
      code    = 5'h00;
      bad_sel = '0;
      if (int_sel) begin
         code = 5'h01;
      end else if (exc_flags_i[0]) begin
         code    = 5'h04;
         bad_sel = pc_i;
      end else if (exc_flags_i[1]) begin
         code = 5'h0a;
      end else if (exc_flags_i[2]) begin
         code = 5'h08;
      end else if (exc_flags_i[3]) begin
         code = 5'h09;
      end else if (exc_flags_i[4]) begin
         code = 5'h0d;
      end else if (exc_flags_i[5]) begin
         code = 5'h0c;
      end else if (exc_flags_i[6]) begin
         code    = 5'h04;
         bad_sel = mem_addr_i;
      end else if (exc_flags_i[7]) begin
         code    = 5'h05;
         bad_sel = mem_addr_i;
      end else if (exc_flags_i[8]) begin
         code = 5'h0e;
      end
   end

   always_comb begin
      int_o               = rst ? 6'd0 : int_vec;
      current_inst_addr_o = rst ? 32'd0 : pc_i;
      is_in_delayslot_o   = ~rst & is_in_delayslot_i;
      flush_o             = commit;
      excepttype_o        = '0;
      bad_addr_o          = '0;
      newpc_o             = '0;
      if (commit) begin
         excepttype_o = {27'd0, code};
         bad_addr_o   = bad_sel;
         newpc_o      = (code == 5'h0e) ? epc_f : EXC_VECTOR;
      end
   end

   assign unused_bits = ^{status_f[31:16], status_f[7:2], cp0_cause_i[31:10], cp0_cause_i[7:0]};

endmodule

// File: tb/tb_exc_arbiter.sv
// Directed bench for exc_arbiter: a vector table for single-commit priority cases
// plus hand-written sequences for interrupts, stalls, forwarding and reset.
module tb_exc_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i, stall_i, is_in_delayslot_i, timer_int_i, cp0_we_i;
   logic [31:0] pc_i, mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_wdata_i;
   logic [8:0]  exc_flags_i;
   logic [5:0]  ext_int_i;
   logic [4:0]  cp0_waddr_i;
   logic [5:0]  int_o;
   logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;
   logic        is_in_delayslot_o, flush_o;

   int passed = 0;
   int total  = 0;

   localparam logic [31:0] VEC = 32'hBFC00380;

   exc_arbiter dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .pc_i(pc_i),
      .is_in_delayslot_i(is_in_delayslot_i), .mem_addr_i(mem_addr_i),
      .exc_flags_i(exc_flags_i), .ext_int_i(ext_int_i), .timer_int_i(timer_int_i),
      .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
      .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
      .int_o(int_o), .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
      .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o), .flush_o(flush_o),
      .newpc_o(newpc_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid, stall, ds;
      logic [31:0] pc, maddr;
      logic [8:0]  flags;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata, epc;
      logic [31:0] e_type;
      logic        e_flush;
      logic [31:0] e_newpc, e_bad;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid_i = 0; stall_i = 0; is_in_delayslot_i = 0; timer_int_i = 0; cp0_we_i = 0;
      pc_i = 0; mem_addr_i = 0; cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
      cp0_wdata_i = 0; exc_flags_i = 0; ext_int_i = 0; cp0_waddr_i = 0;
   endtask

   task automatic addv(input logic valid, input logic stall, input logic ds,
                       input logic [31:0] pc, input logic [31:0] maddr, input logic [8:0] flags,
                       input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic [31:0] epc, input logic [31:0] e_type, input logic e_flush,
                       input logic [31:0] e_newpc, input logic [31:0] e_bad);
      vec_t v;
      v.valid = valid; v.stall = stall; v.ds = ds; v.pc = pc; v.maddr = maddr; v.flags = flags;
      v.we = we; v.waddr = waddr; v.wdata = wdata; v.epc = epc; v.e_type = e_type;
      v.e_flush = e_flush; v.e_newpc = e_newpc; v.e_bad = e_bad;
      vecs.push_back(v);
   endtask

   initial begin
      //   valid stall ds pc            maddr         flags    we waddr  wdata          epc            type    fl newpc          bad
      addv(1, 0, 0, 32'h8000_0010, 32'h0,        9'h004, 0, 5'd0,  32'h0,         32'h0,         32'h8, 1, VEC,           32'h0);
      addv(1, 0, 0, 32'h8000_0014, 32'h1003,     9'h060, 0, 5'd0,  32'h0,         32'h0,         32'hc, 1, VEC,           32'h0);
      addv(1, 0, 0, 32'h8000_0014, 32'h1003,     9'h040, 0, 5'd0,  32'h0,         32'h0,         32'h4, 1, VEC,           32'h1003);
      addv(1, 0, 0, 32'h8000_0018, 32'h2002,     9'h080, 0, 5'd0,  32'h0,         32'h0,         32'h5, 1, VEC,           32'h2002);
      addv(1, 0, 1, 32'h8000_0021, 32'h3000,     9'h003, 0, 5'd0,  32'h0,         32'h0,         32'h4, 1, VEC,           32'h8000_0021);
      addv(1, 0, 0, 32'h8000_0024, 32'h0,        9'h002, 0, 5'd0,  32'h0,         32'h0,         32'ha, 1, VEC,           32'h0);
      addv(1, 0, 0, 32'h8000_0028, 32'h0,        9'h018, 0, 5'd0,  32'h0,         32'h0,         32'h9, 1, VEC,           32'h0);
      addv(1, 0, 0, 32'h8000_002c, 32'h0,        9'h010, 0, 5'd0,  32'h0,         32'h0,         32'hd, 1, VEC,           32'h0);
      addv(1, 0, 0, 32'h8000_0030, 32'h0,        9'h100, 1, 5'd14, 32'h8000_0200, 32'h8000_0100, 32'he, 1, 32'h8000_0200, 32'h0);
      addv(1, 0, 0, 32'h8000_0034, 32'h0,        9'h100, 1, 5'd13, 32'h8000_0200, 32'h8000_0100, 32'he, 1, 32'h8000_0100, 32'h0);
      addv(1, 0, 0, 32'h8000_0038, 32'h0,        9'h120, 0, 5'd0,  32'h0,         32'h8000_0100, 32'hc, 1, VEC,           32'h0);
      addv(0, 0, 0, 32'h8000_003c, 32'h0,        9'h004, 0, 5'd0,  32'h0,         32'h0,         32'h0, 0, 32'h0,         32'h0);
      addv(1, 0, 0, 32'h8000_0040, 32'h0,        9'h000, 0, 5'd0,  32'h0,         32'h0,         32'h0, 0, 32'h0,         32'h0);
      addv(1, 1, 0, 32'h8000_0044, 32'h0,        9'h004, 0, 5'd0,  32'h0,         32'h0,         32'h0, 0, 32'h0,         32'h0);

      // reset: outputs forced to zero even with live inputs
      idle();
      rst = 1; timer_int_i = 1; valid_i = 1; exc_flags_i = 9'h004; pc_i = 32'h1234;
      cyc(); cyc();
      #4;
      chk("rst_int", {26'd0, int_o}, 32'h0);
      chk("rst_flush", {31'd0, flush_o}, 32'h0);
      chk("rst_type", excepttype_o, 32'h0);
      chk("rst_newpc", newpc_o, 32'h0);
      cyc();
      rst = 0; idle();

      foreach (vecs[i]) begin
         cyc();
         valid_i = vecs[i].valid; stall_i = vecs[i].stall; is_in_delayslot_i = vecs[i].ds;
         pc_i = vecs[i].pc; mem_addr_i = vecs[i].maddr; exc_flags_i = vecs[i].flags;
         cp0_we_i = vecs[i].we; cp0_waddr_i = vecs[i].waddr; cp0_wdata_i = vecs[i].wdata;
         cp0_epc_i = vecs[i].epc;
         #4;
         chk($sformatf("v%0d_type", i), excepttype_o, vecs[i].e_type);
         chk($sformatf("v%0d_flush", i), {31'd0, flush_o}, {31'd0, vecs[i].e_flush});
         chk($sformatf("v%0d_newpc", i), newpc_o, vecs[i].e_newpc);
         chk($sformatf("v%0d_bad", i), bad_addr_o, vecs[i].e_bad);
         chk($sformatf("v%0d_pc", i), current_inst_addr_o, vecs[i].pc);
         chk($sformatf("v%0d_ds", i), {31'd0, is_in_delayslot_o}, {31'd0, vecs[i].ds});
         if (vecs[i].e_flush) begin
            cyc();
            #4;
            chk($sformatf("v%0d_blk_flush", i), {31'd0, flush_o}, 32'h0);
            chk($sformatf("v%0d_blk_type", i), excepttype_o, 32'h0);
         end
         cyc();
         idle();
      end

      // timer interrupt reaches int_o[5] without synchroniser delay
      cyc();
      idle(); timer_int_i = 1; valid_i = 1;
      #4;
      chk("timer_int", {26'd0, int_o}, 32'h20);
      chk("timer_masked", excepttype_o, 32'h0);

      // ext_int[0] pulse: two-cycle sync latency, then taken in a delay slot
      cyc();
      idle(); cp0_status_i = 32'h0000_0401; ext_int_i = 6'h01;
      cyc();
      ext_int_i = 6'h00;
      #4;
      chk("int_lat1", {26'd0, int_o}, 32'h0);
      cyc();
      #4;
      chk("int_lat2", {26'd0, int_o}, 32'h1);
      chk("int_novalid", excepttype_o, 32'h0);
      cyc();
      valid_i = 1; is_in_delayslot_i = 1; pc_i = 32'h8000_0040;
      #4;
      chk("int_type", excepttype_o, 32'h1);
      chk("int_flush", {31'd0, flush_o}, 32'h1);
      chk("int_ds", {31'd0, is_in_delayslot_o}, 32'h1);
      chk("int_pc", current_inst_addr_o, 32'h8000_0040);
      chk("int_newpc", newpc_o, VEC);
      cyc();
      #4;
      chk("int_blk", {31'd0, flush_o}, 32'h0);
      cyc();
      #4;
      chk("int_done", excepttype_o, 32'h0);

      // pending interrupt masked by same-cycle mtc0 status=0
      cyc();
      idle(); cp0_status_i = 32'h0000_0401; ext_int_i = 6'h01;
      cyc();
      ext_int_i = 6'h00;
      cyc();
      cyc();
      valid_i = 1; pc_i = 32'h8000_0050; cp0_we_i = 1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'h0;
      #4;
      chk("mtc0_mask_type", excepttype_o, 32'h0);
      chk("mtc0_mask_flush", {31'd0, flush_o}, 32'h0);
      cyc();
      cp0_we_i = 0;
      #4;
      chk("mtc0_after", excepttype_o, 32'h0);

      // ri held under stall: no flush until stall drops, then a single pulse
      cyc();
      idle(); valid_i = 1; stall_i = 1; exc_flags_i = 9'h002; pc_i = 32'h8000_0060;
      for (int k = 0; k < 3; k++) begin
         #4;
         chk($sformatf("stall%0d_flush", k), {31'd0, flush_o}, 32'h0);
         cyc();
      end
      stall_i = 0;
      #4;
      chk("stall_rel_type", excepttype_o, 32'ha);
      chk("stall_rel_flush", {31'd0, flush_o}, 32'h1);
      cyc();
      #4;
      chk("stall_blk", {31'd0, flush_o}, 32'h0);

      // rst mid-stall with an interrupt pending
      cyc();
      idle(); valid_i = 1; stall_i = 1; exc_flags_i = 9'h002; cp0_status_i = 32'h0000_0401;
      ext_int_i = 6'h01; pc_i = 32'h8000_0070;
      cyc(); cyc(); cyc();
      #4;
      chk("rs_stall_type", excepttype_o, 32'h0);
      chk("rs_int", {26'd0, int_o}, 32'h1);
      cyc();
      rst = 1; timer_int_i = 1;
      #4;
      chk("rs_rst_int", {26'd0, int_o}, 32'h0);
      chk("rs_rst_flush", {31'd0, flush_o}, 32'h0);
      chk("rs_rst_pc", current_inst_addr_o, 32'h0);
      cyc();
      rst = 0; timer_int_i = 0; ext_int_i = 0; stall_i = 0; exc_flags_i = 0;
      #4;
      chk("rs_pend_clr", excepttype_o, 32'h0);
      cyc();
      exc_flags_i = 9'h004; cp0_status_i = 0;
      #4;
      chk("rs_commit", excepttype_o, 32'h8);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/exc_arbiter.md
Name: exc_arbiter

Overview:
- MEM-stage exception collector and arbiter. It is the producer side of the CP0 exception interface.
- Synchronises external interrupt lines and forwards in-flight mtc0 writes to status/cause/epc.
- Prioritises per-instruction exception flags and emits a one-cycle exception commit (type, pc, delay-slot flag, bad address) to CP0.
- Emits a pipeline flush and redirect PC. Located between the MEM pipeline register and the CP0 register file.

Parameters:
- SYNC_STAGES, 2, depth of the flop synchroniser on ext_int_i (minimum 2).
- EXC_VECTOR, 32'hBFC00380, redirect address for all exceptions except eret.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- valid_i  in  1  instruction in MEM is valid (not a bubble)
- stall_i  in  1  MEM stage stalled; no commit allowed
- pc_i  in  32  PC of the MEM instruction
- is_in_delayslot_i  in  1  MEM instruction is in a branch delay slot
- mem_addr_i  in  32  load/store effective address
- exc_flags_i  in  9  one-hot-capable flags: [0] adel_if, [1] ri, [2] syscall, [3] break, [4] trap, [5] ov, [6] adel_ld, [7] ades_st, [8] eret
- ext_int_i  in  6  asynchronous hardware interrupt lines
- timer_int_i  in  1  CP0 timer interrupt, already synchronous
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values
- cp0_we_i  in  1  WB-stage mtc0 write enable
- cp0_waddr_i  in  5  WB-stage mtc0 address (status=12, cause=13, epc=14)
- cp0_wdata_i  in  32  WB-stage mtc0 data
- int_o  out  6  synchronised interrupt vector to CP0 int_i; bit5 = sync[5] | timer_int_i
- excepttype_o  out  32  exception code to CP0; 0 when none
- current_inst_addr_o  out  32  pc of the committing instruction
- is_in_delayslot_o  out  1  delay-slot flag of the committing instruction
- bad_addr_o  out  32  faulting address for code 0x4/0x5, else 0
- flush_o  out  1  one-cycle pipeline flush
- newpc_o  out  32  redirect target, valid when flush_o=1

Behaviour:
- Reset values:
  - Synchroniser flops, int_pend_q and block_q clear to 0.
  - All outputs read 0 (int_o=0, flush_o=0, excepttype_o=0, newpc_o=0).
- Synchroniser: ext_int_i passes through SYNC_STAGES flops, giving SYNC_STAGES cycles of latency to int_o.
- Forwarding: status_f/epc_f = cp0_wdata_i when cp0_we_i and the address matches, else the cp0_*_i value. cause_f[9:8] is forwarded the same way. cause_f[15:10] always comes from int_o.
- Interrupt condition: int_req = status_f[0] & ~status_f[1] & |(cause_f[15:8] & status_f[15:8]).
- Interrupt pending latch int_pend_q:
  - Set when int_req=1.
  - Cleared when an interrupt commits, or when int_req falls while no commit has happened.
- commit_ok = valid_i & ~stall_i & ~block_q.
- Priority when commit_ok=1, highest first:
  - interrupt (int_pend_q|int_req) → 0x1
  - adel_if → 0x4, bad_addr=pc_i
  - ri → 0xa
  - syscall → 0x8
  - break → 0x9
  - trap → 0xd
  - ov → 0xc
  - adel_ld → 0x4, bad_addr=mem_addr_i
  - ades_st → 0x5, bad_addr=mem_addr_i
  - eret → 0xe
- Commit cycle (all outputs combinational in that cycle, so CP0 samples them at the same edge):
  - excepttype_o = selected code.
  - current_inst_addr_o = pc_i; is_in_delayslot_o = is_in_delayslot_i.
  - flush_o = 1.
  - newpc_o = epc_f for 0xe, else EXC_VECTOR.
- block_q is set for exactly the one cycle after any commit. That cycle's valid_i belongs to the flushed bubble and is ignored.
- No commit (stall, invalid, blocked, or no flag):
  - excepttype_o=0, flush_o=0.
  - current_inst_addr_o = pc_i, is_in_delayslot_o = is_in_delayslot_i, bad_addr_o=0.
- Stall with a flag raised: nothing is emitted. The commit occurs in the first cycle with stall_i=0 while valid_i is still 1. Exactly one pulse per instruction.
- mtc0 status clearing IE in WB while an interrupt is pending: the forwarded value masks it, so no interrupt is taken.
- eret with EXL=1 followed by an interrupt: the interrupt is taken no earlier than the cycle after block_q clears.
- rst asserted mid-stall: the pending latch and block_q clear, and no commit follows.

Test Plan:
- exc_flags_i=9'h004 (syscall), pc_i=32'h8000_0010, valid, no stall → one cycle with excepttype_o=0x8, flush_o=1, newpc_o=32'hBFC00380; the next cycle excepttype_o=0.
- Flags adel_ld|ov together, mem_addr_i=32'h1003 → excepttype_o=0xc and bad_addr_o=0. Then adel_ld alone → 0x4 with bad_addr_o=32'h1003.
- status=32'h0000_0401, ext_int_i[0] pulsed → int_o[0] rises 2 cycles later → excepttype_o=0x1 on the next valid instruction. In a delay slot, is_in_delayslot_o=1 with current_inst_addr_o=pc_i.
- eret with cp0_epc_i=32'h8000_0100, and the same-cycle mtc0 epc=32'h8000_0200 in WB → newpc_o=32'h8000_0200, excepttype_o=0xe.
- ri flag held with stall_i=1 for 3 cycles → no flush. Stall drops → a single flush_o pulse; block_q suppresses the following cycle.
- Pending interrupt with mtc0 status=0 in the same cycle → no commit; rst mid-stall → all outputs 0.
